// File: rtl/car_link_pkg.sv
// Definitions shared by both ends of the car/simulator serial link: command bit layout,
// transmitter state encoding and default line timing.
package car_link_pkg;

    localparam int unsigned CMD_FWD     = 0;
    localparam int unsigned CMD_BACK    = 1;
    localparam int unsigned CMD_LEFT    = 2;
    localparam int unsigned CMD_RIGHT   = 3;
    localparam int unsigned CMD_PLACE   = 4;
    localparam int unsigned CMD_DESTROY = 5;

    localparam int unsigned DEFAULT_CLK_HZ = 100_000_000;
    localparam int unsigned DEFAULT_BAUD   = 9600;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of
// each bit period.
module baud_tick_gen #(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (tick_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cmd_uart_tx.sv
// Transmit side of the car/simulator link: sends the drive command byte as UART 8N1 on
// every change and re-sends it periodically so the simulator recovers from a lost frame.
module cmd_uart_tx
    import car_link_pkg::*;
#(
    parameter int unsigned CLK_HZ         = DEFAULT_CLK_HZ,
    parameter int unsigned BAUD           = DEFAULT_BAUD,
    parameter int unsigned REFRESH_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       power,
    input  logic [7:0] cmd_in,
    output logic       tx,
    output logic       busy,
    output logic       sent_pulse
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned REFRESH_W    = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
    // Pending is raised on the edge that would take the counter to REFRESH_CYCLES-1.
    localparam logic [REFRESH_W-1:0] REFRESH_HIT = REFRESH_W'(REFRESH_CYCLES - 2);

    tx_state_e            state_q, state_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [7:0]           shadow_q, shadow_d;
    logic [7:0]           last_sent_q, last_sent_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 sent_pulse_q, sent_pulse_d;
    logic [REFRESH_W-1:0] refresh_cnt_q, refresh_cnt_d;
    logic                 refresh_pending_q, refresh_pending_d;

    logic       frame_start;
    logic       baud_tick;
    logic       refresh_hit;
    logic [2:0] bit_idx_nxt;

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick_gen (
        .clk_i  (clk),
        .rst_ni (power),
        .clear_i(frame_start),
        .en_i   (busy_q),
        .tick_o (baud_tick)
    );

    assign refresh_hit = (refresh_cnt_q == REFRESH_HIT);
    assign bit_idx_nxt = bit_idx_q + 3'd1;

    always_comb begin
        state_d           = state_q;
        bit_idx_d         = bit_idx_q;
        shadow_d          = shadow_q;
        last_sent_d       = last_sent_q;
        tx_d              = tx_q;
        busy_d            = busy_q;
        sent_pulse_d      = 1'b0;
        frame_start       = 1'b0;
        refresh_cnt_d     = refresh_hit ? '0 : refresh_cnt_q + 1'b1;
        refresh_pending_d = refresh_pending_q | refresh_hit;

        unique case (state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if ((cmd_in != last_sent_q) || refresh_pending_q) begin
                    frame_start       = 1'b1;
                    shadow_d          = cmd_in;
                    last_sent_d       = cmd_in;
                    state_d           = TX_START;
                    tx_d              = 1'b0;
                    busy_d            = 1'b1;
                    refresh_cnt_d     = '0;
                    refresh_pending_d = 1'b0;
                end
            end
            TX_START: begin
                if (baud_tick) begin
                    state_d   = TX_DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = shadow_q[0];
                end
            end
            TX_DATA: begin
                if (baud_tick) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_nxt;
                        tx_d      = shadow_q[bit_idx_nxt];
                    end
                end
            end
            TX_STOP: begin
                if (baud_tick) begin
                    state_d      = TX_IDLE;
                    busy_d       = 1'b0;
                    sent_pulse_d = 1'b1;
                end
            end
            default: begin
                state_d = TX_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge power) begin
        if (!power) begin
            state_q           <= TX_IDLE;
            bit_idx_q         <= 3'd0;
            shadow_q          <= 8'h00;
            last_sent_q       <= 8'h00;
            tx_q              <= 1'b1;
            busy_q            <= 1'b0;
            sent_pulse_q      <= 1'b0;
            refresh_cnt_q     <= '0;
            refresh_pending_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            bit_idx_q         <= bit_idx_d;
            shadow_q          <= shadow_d;
            last_sent_q       <= last_sent_d;
            tx_q              <= tx_d;
            busy_q            <= busy_d;
            sent_pulse_q      <= sent_pulse_d;
            refresh_cnt_q     <= refresh_cnt_d;
            refresh_pending_q <= refresh_pending_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign sent_pulse = sent_pulse_q;

endmodule

// File: tb/tb_cmd_uart_tx.sv
// Self-checking bench for cmd_uart_tx: directed scenarios plus random command traffic,
// compared cycle by cycle against a frame-level reference model.
module tb_cmd_uart_tx;

    localparam int CLK_HZ  = 1_000_000;
    localparam int BAUD    = 100_000;
    localparam int REFRESH = 1000;
    localparam int CPB     = CLK_HZ / BAUD;
    localparam int FRAME   = 10 * CPB;

    logic       clk = 1'b0;
    logic       power = 1'b0;
    logic [7:0] cmd_in = 8'h00;
    logic       tx, busy, sent_pulse;

    int total = 0;
    int bad = 0;

    cmd_uart_tx #(
        .CLK_HZ(CLK_HZ),
        .BAUD(BAUD),
        .REFRESH_CYCLES(REFRESH)
    ) dut (
        .clk(clk),
        .power(power),
        .cmd_in(cmd_in),
        .tx(tx),
        .busy(busy),
        .sent_pulse(sent_pulse)
    );

    always #5 clk = ~clk;

    // Reference model: a frame is a 10-bit vector, the line shows bit (cycle / CPB).
    bit         m_busy = 0;
    int         m_cyc = 0;
    logic [9:0] m_frame = '1;
    logic [7:0] m_last = 8'h00;
    bit         m_pend = 0;
    int         m_elapsed = 0;
    bit         m_pulse = 0;

    always @(posedge clk or negedge power) begin
        bit start;
        if (!power) begin
            m_busy = 0; m_cyc = 0; m_frame = '1; m_last = 8'h00;
            m_pend = 0; m_elapsed = 0; m_pulse = 0;
        end else begin
            start = !m_busy && ((cmd_in != m_last) || m_pend);
            m_pulse = 0;
            m_elapsed = m_elapsed + 1;
            if (m_elapsed == REFRESH - 1) begin
                m_pend = 1;
                m_elapsed = 0;
            end
            if (m_busy) begin
                if (m_cyc == FRAME - 1) begin
                    m_busy = 0;
                    m_pulse = 1;
                end else begin
                    m_cyc = m_cyc + 1;
                end
            end
            if (start) begin
                m_frame = {1'b1, cmd_in, 1'b0};
                m_last = cmd_in;
                m_busy = 1;
                m_cyc = 0;
                m_pend = 0;
                m_elapsed = 0;
            end
        end
    end

    logic exp_tx;
    always_comb exp_tx = m_busy ? m_frame[m_cyc / CPB] : 1'b1;

    task automatic test_reset();
        power = 1'b0;
        cmd_in = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({tx, busy, sent_pulse} !== 3'b100) begin
                bad++;
                $display("FAIL reset cyc=%0d tx/busy/pulse=%b%b%b want 100", i, tx, busy,
                         sent_pulse);
            end
        end
    endtask

    task automatic test_first_frame();
        logic [9:0] samp = '0;
        logic [9:0] want = {1'b1, 8'h01, 1'b0};
        int busy_cnt = 0;
        int pulse_cnt = 0;
        int pulse_at = -1;
        cmd_in = 8'h01;
        power = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            total++;
            if ({tx, busy, sent_pulse} !== {exp_tx, m_busy, m_pulse}) begin
                bad++;
                $display("FAIL first_frame cyc=%0d got=%b%b%b want=%b%b%b", i, tx, busy,
                         sent_pulse, exp_tx, m_busy, m_pulse);
            end
            if (busy === 1'b1) busy_cnt++;
            if (sent_pulse === 1'b1) begin
                pulse_cnt++;
                pulse_at = i;
            end
            if (i < FRAME && (i % CPB) == CPB / 2) samp[i / CPB] = tx;
        end
        total += 4;
        if (samp !== want) begin
            bad++;
            $display("FAIL first_frame_bits got=%b want=%b", samp, want);
        end
        if (busy_cnt != FRAME) begin
            bad++;
            $display("FAIL first_frame_busy got=%0d want=%0d", busy_cnt, FRAME);
        end
        if (pulse_cnt != 1) begin
            bad++;
            $display("FAIL first_frame_pulses got=%0d want=1", pulse_cnt);
        end
        if (pulse_at != FRAME) begin
            bad++;
            $display("FAIL first_frame_pulse_at got=%0d want=%0d", pulse_at, FRAME);
        end
    endtask

    task automatic test_change_mid_frame();
        logic [9:0] samp1 = '0;
        logic [9:0] samp2 = '0;
        logic [9:0] want1 = {1'b1, 8'h01, 1'b0};
        logic [9:0] want2 = {1'b1, 8'h08, 1'b0};
        int second = -1;
        logic prev = 1'b0;
        @(negedge clk);
        power = 1'b0;
        cmd_in = 8'h01;
        @(negedge clk);
        power = 1'b1;
        for (int i = 0; i < 230; i++) begin
            @(negedge clk);
            total++;
            if ({tx, busy, sent_pulse} !== {exp_tx, m_busy, m_pulse}) begin
                bad++;
                $display("FAIL change_mid cyc=%0d got=%b%b%b want=%b%b%b", i, tx, busy,
                         sent_pulse, exp_tx, m_busy, m_pulse);
            end
            if (i > 0 && busy === 1'b1 && prev === 1'b0 && second < 0) second = i;
            prev = busy;
            if (i < FRAME && (i % CPB) == CPB / 2) samp1[i / CPB] = tx;
            if (second > 0 && i >= second && i < second + FRAME && ((i - second) % CPB) == CPB / 2)
                samp2[(i - second) / CPB] = tx;
            if (i == 30) cmd_in = 8'h08;
        end
        total += 3;
        if (samp1 !== want1) begin
            bad++;
            $display("FAIL change_mid_frame1 got=%b want=%b", samp1, want1);
        end
        if (second != FRAME + 1) begin
            bad++;
            $display("FAIL change_mid_gap second_start got=%0d want=%0d", second, FRAME + 1);
        end
        if (samp2 !== want2) begin
            bad++;
            $display("FAIL change_mid_frame2 got=%b want=%b", samp2, want2);
        end
    endtask

    task automatic test_refresh();
        int starts[$];
        logic prev = 1'b0;
        @(negedge clk);
        cmd_in = 8'h04;
        for (int i = 0; i < 3500; i++) begin
            @(negedge clk);
            total++;
            if ({tx, busy, sent_pulse} !== {exp_tx, m_busy, m_pulse}) begin
                bad++;
                $display("FAIL refresh cyc=%0d got=%b%b%b want=%b%b%b", i, tx, busy,
                         sent_pulse, exp_tx, m_busy, m_pulse);
            end
            if (busy === 1'b1 && prev === 1'b0) starts.push_back(i);
            prev = busy;
        end
        total++;
        if (starts.size() != 4) begin
            bad++;
            $display("FAIL refresh_count got=%0d want=4", starts.size());
        end
        for (int k = 1; k < starts.size(); k++) begin
            total++;
            if (starts[k] - starts[k-1] != REFRESH) begin
                bad++;
                $display("FAIL refresh_period k=%0d got=%0d want=%0d", k,
                         starts[k] - starts[k-1], REFRESH);
            end
        end
    endtask

    task automatic test_power_drop();
        logic [9:0] samp = '0;
        logic [9:0] want = {1'b1, 8'h20, 1'b0};
        @(negedge clk);
        cmd_in = 8'h20;
        for (int i = 0; i <= 45; i++) begin
            @(negedge clk);
            total++;
            if ({tx, busy, sent_pulse} !== {exp_tx, m_busy, m_pulse}) begin
                bad++;
                $display("FAIL power_drop_pre cyc=%0d got=%b%b%b want=%b%b%b", i, tx, busy,
                         sent_pulse, exp_tx, m_busy, m_pulse);
            end
        end
        #2 power = 1'b0;
        #1;
        total++;
        if ({tx, busy, sent_pulse} !== 3'b100) begin
            bad++;
            $display("FAIL power_drop_async got=%b%b%b want=100", tx, busy, sent_pulse);
        end
        @(negedge clk);
        power = 1'b1;
        for (int i = 0; i < 110; i++) begin
            @(negedge clk);
            total++;
            if ({tx, busy, sent_pulse} !== {exp_tx, m_busy, m_pulse}) begin
                bad++;
                $display("FAIL power_drop_post cyc=%0d got=%b%b%b want=%b%b%b", i, tx, busy,
                         sent_pulse, exp_tx, m_busy, m_pulse);
            end
            if (i < FRAME && (i % CPB) == CPB / 2) samp[i / CPB] = tx;
        end
        total++;
        if (samp !== want) begin
            bad++;
            $display("FAIL power_drop_refrm got=%b want=%b", samp, want);
        end
    endtask

    task automatic test_zero_cmd();
        logic [9:0] samp = '0;
        logic [9:0] want = {1'b1, 8'h00, 1'b0};
        int first = -1;
        @(negedge clk);
        power = 1'b0;
        cmd_in = 8'h00;
        @(negedge clk);
        power = 1'b1;
        for (int i = 0; i < 1120; i++) begin
            @(negedge clk);
            total++;
            if ({tx, busy, sent_pulse} !== {exp_tx, m_busy, m_pulse}) begin
                bad++;
                $display("FAIL zero_cmd cyc=%0d got=%b%b%b want=%b%b%b", i, tx, busy,
                         sent_pulse, exp_tx, m_busy, m_pulse);
            end
            if (busy === 1'b1 && first < 0) first = i;
            if (first >= 0 && i < first + FRAME && ((i - first) % CPB) == CPB / 2)
                samp[(i - first) / CPB] = tx;
        end
        total += 2;
        if (first != REFRESH - 1) begin
            bad++;
            $display("FAIL zero_cmd_first got=%0d want=%0d", first, REFRESH - 1);
        end
        if (samp !== want) begin
            bad++;
            $display("FAIL zero_cmd_bits got=%b want=%b", samp, want);
        end
    endtask

    task automatic test_glitch();
        int s = -1;
        int extra = 0;
        int next = -1;
        logic prev = busy;
        for (int i = 0; i < 3 * REFRESH; i++) begin
            @(negedge clk);
            total++;
            if ({tx, busy, sent_pulse} !== {exp_tx, m_busy, m_pulse}) begin
                bad++;
                $display("FAIL glitch cyc=%0d got=%b%b%b want=%b%b%b", i, tx, busy,
                         sent_pulse, exp_tx, m_busy, m_pulse);
            end
            if (busy === 1'b1 && prev === 1'b0) begin
                if (s < 0) s = i;
                else if (i - s == REFRESH) next = i;
                else extra++;
            end
            prev = busy;
            if (s >= 0 && i == s + 20) cmd_in = 8'h10;
            if (s >= 0 && i == s + 40) cmd_in = 8'h00;
            if (s >= 0 && i == s + REFRESH + 20) break;
        end
        total += 2;
        if (s < 0 || next < 0) begin
            bad++;
            $display("FAIL glitch_refresh first=%0d next=%0d want gap %0d", s, next, REFRESH);
        end
        if (extra != 0) begin
            bad++;
            $display("FAIL glitch_extra got=%0d want=0", extra);
        end
    endtask

    task automatic test_back_to_back_random();
        for (int n = 0; n < 300; n++) begin
            int hold;
            if ($urandom_range(0, 3) != 0) cmd_in = 8'($urandom);
            hold = $urandom_range(1, 160);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                total++;
                if ({tx, busy, sent_pulse} !== {exp_tx, m_busy, m_pulse}) begin
                    bad++;
                    $display("FAIL random n=%0d cyc=%0d got=%b%b%b want=%b%b%b", n, i, tx,
                             busy, sent_pulse, exp_tx, m_busy, m_pulse);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_change_mid_frame();
        test_refresh();
        test_power_drop();
        test_zero_cmd();
        test_glitch();
        test_back_to_back_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
